// File: rtl/sdram_port_arbiter.sv
// Grants the SDRAM command scheduler to one AHB port access or one refresh at a time.
// Round-robin between ports, refresh first, write-before-read on wbr, watchdog release.
module sdram_port_arbiter #(
  parameter int PORTS       = 2,
  parameter int PW          = (PORTS > 1) ? $clog2(PORTS) : 1,
  parameter int TIMEOUT_CNT = 256
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             ena_i,
  input  logic [PORTS-1:0] rdreq_i,
  input  logic [PORTS-1:0] wrreq_i,
  input  logic [PORTS-1:0] wbr_i,
  input  logic             ref_req_i,
  input  logic             ref_done_i,
  input  logic             done_i,
  output logic [PORTS-1:0] gnt_o,
  output logic [PW-1:0]    gnt_port_o,
  output logic             gnt_wr_o,
  output logic             gnt_vld_o,
  output logic             ref_gnt_o,
  output logic             timeout_o
);

  localparam int            TW   = $clog2(TIMEOUT_CNT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PGNT = 2'd1,
    ST_RGNT = 2'd2
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    last_q;
  logic [TW-1:0]    timer_q;
  logic [PORTS-1:0] gnt_q;
  logic [PW-1:0]    port_q;
  logic             wr_q;
  logic             vld_q;
  logic             ref_gnt_q;
  logic             timeout_q;

  logic [PORTS-1:0] req_s;
  logic [PW-1:0]    cand_s;
  logic             win_found_d;
  logic [PW-1:0]    win_d;
  logic             win_wr_d;
  logic [PORTS-1:0] win_onehot_d;
  logic             timer_hit_s;

  assign req_s       = rdreq_i | wrreq_i;
  assign timer_hit_s = (timer_q == TMAX);

  // Round-robin search starting just after the last served port.
  always_comb begin
    win_found_d = 1'b0;
    win_d       = {PW{1'b0}};
    cand_s      = {PW{1'b0}};
    for (int i = 1; i <= PORTS; i++) begin
      cand_s = PW'((32'(last_q) + 32'(i)) % 32'(PORTS));
      if (!win_found_d && req_s[cand_s]) begin
        win_found_d = 1'b1;
        win_d       = cand_s;
      end else begin
        win_found_d = win_found_d;
      end
    end
  end

  // Access type and one-hot vector for the winning port.
  always_comb begin
    win_wr_d     = wrreq_i[win_d] & (wbr_i[win_d] | ~rdreq_i[win_d]);
    win_onehot_d = PORTS'(1'b1) << win_d;
  end

  // Grant FSM; all outputs registered, watchdog shared by both grant states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      last_q    <= PW'(PORTS - 1);
      timer_q   <= {TW{1'b0}};
      gnt_q     <= {PORTS{1'b0}};
      port_q    <= {PW{1'b0}};
      wr_q      <= 1'b0;
      vld_q     <= 1'b0;
      ref_gnt_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ref_req_i) begin
            state_q   <= ST_RGNT;
            ref_gnt_q <= 1'b1;
            timer_q   <= {TW{1'b0}};
          end else if (ena_i && win_found_d) begin
            state_q <= ST_PGNT;
            gnt_q   <= win_onehot_d;
            port_q  <= win_d;
            wr_q    <= win_wr_d;
            vld_q   <= 1'b1;
            timer_q <= {TW{1'b0}};
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PGNT: begin
          if (done_i || timer_hit_s) begin
            // A done coinciding with the watchdog expiry is a normal completion.
            state_q   <= ST_IDLE;
            last_q    <= port_q;
            gnt_q     <= {PORTS{1'b0}};
            port_q    <= {PW{1'b0}};
            wr_q      <= 1'b0;
            vld_q     <= 1'b0;
            timeout_q <= ~done_i;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RGNT: begin
          if (ref_done_i || timer_hit_s) begin
            state_q   <= ST_IDLE;
            ref_gnt_q <= 1'b0;
            timeout_q <= ~ref_done_i;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          gnt_q     <= {PORTS{1'b0}};
          port_q    <= {PW{1'b0}};
          wr_q      <= 1'b0;
          vld_q     <= 1'b0;
          ref_gnt_q <= 1'b0;
          timer_q   <= {TW{1'b0}};
        end
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_port_o = port_q;
  assign gnt_wr_o   = wr_q;
  assign gnt_vld_o  = vld_q;
  assign ref_gnt_o  = ref_gnt_q;
  assign timeout_o  = timeout_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM command scheduler between AHB ports and the periodic refresh engine; sits between the per-port AHB interfaces and the command scheduler in the HCLK domain.
- Each grant goes to one requester, either one port's read or write, or one refresh.
- Port selection is round-robin. Refresh has absolute priority. A write is forced ahead of a read when the port flags a write-buffer hit (wbr).
- A watchdog releases a grant the scheduler never completes.

Parameters:
- PORTS, 2, number of AHB ports (1..16)
- PW, $clog2(PORTS) min 1, width of port index
- TIMEOUT_CNT, 256, max HCLK cycles a grant may be held before forced release (>=2)

Ports:
- HCLK  in  1  clock, rising edge
- HRESETn  in  1  asynchronous active-low reset
- ena_i  in  1  controller enable (CSR); low blocks new port grants
- rdreq_i  in  PORTS  per-port read request, level
- wrreq_i  in  PORTS  per-port write request, level
- wbr_i  in  PORTS  per-port write-before-read: pending write must be served before that port's read
- ref_req_i  in  1  refresh request, level
- ref_done_i  in  1  refresh complete, 1-cycle pulse
- done_i  in  1  scheduler finished the granted access, 1-cycle pulse
- gnt_o  out  PORTS  one-hot port grant
- gnt_port_o  out  PW  index of granted port
- gnt_wr_o  out  1  1=write grant, 0=read grant
- gnt_vld_o  out  1  a port grant is active
- ref_gnt_o  out  1  refresh grant active
- timeout_o  out  1  1-cycle pulse: grant forcibly released

Behaviour:
- Reset (async, HRESETn=0):
  - All outputs are 0.
  - Round-robin pointer last = PORTS-1, so port 0 has first priority.
  - Timer is 0. State is IDLE.
- FSM states: IDLE, PGNT, RGNT. All outputs are registered.
- IDLE, evaluated in this order:
  - ref_req_i=1: next state RGNT, ref_gnt_o=1 the next cycle. Refresh is granted even when ena_i=0.
  - Else ena_i=1 and any (rdreq_i|wrreq_i):
    - Search ports last+1, last+2, … modulo PORTS. The first port p with rdreq|wrreq wins.
    - Type: write if wrreq[p] and (wbr[p] or !rdreq[p]); otherwise read.
    - Next cycle: gnt_o[p]=1, gnt_port_o=p, gnt_wr_o=type, gnt_vld_o=1; state PGNT.
  - Else stay in IDLE.
  - Latency is 1 cycle from a request seen in IDLE to the grant.
- PGNT:
  - Grant outputs are held stable regardless of changes on request, ena_i or ref_req_i.
  - On done_i=1: next cycle gnt_o=0, gnt_vld_o=0, last=p, state IDLE.
  - At least one IDLE cycle always separates consecutive grants.
- RGNT:
  - ref_gnt_o held until ref_done_i=1; then cleared next cycle, state IDLE.
  - The round-robin pointer is unchanged by a refresh.
- A refresh requested during PGNT waits until the port grant ends. It then wins the next IDLE arbitration over every port.
- Watchdog:
  - Timer clears on entry to PGNT or RGNT and increments each cycle in those states.
  - If it reaches TIMEOUT_CNT-1 without done_i or ref_done_i, the grant is released as if done arrived and timeout_o pulses for 1 cycle.
  - For a port grant, last is updated as for a normal completion.
  - A done arriving in the same cycle as the timeout is a normal completion; timeout_o stays 0.
- Stray pulses:
  - done_i in IDLE or RGNT is ignored.
  - ref_done_i in IDLE or PGNT is ignored.
- ena_i falling during PGNT does not abort the active grant; new port grants are blocked afterwards.
- A port dropping its request while granted has no effect; the scheduler decides completion.
- PORTS=1: the round-robin search degenerates; gnt_port_o is always 0.

Test Plan:
- Reset, ena_i=1, rdreq_i=2'b11 held; done_i pulsed 3 cycles after each grant → grant order port0, port1, port0, …; grant rises 1 cycle after IDLE; one IDLE cycle between grants.
- Port1 asserts rdreq and wrreq with wbr=0, then wbr=1 → gnt_wr_o=0 the first time, gnt_wr_o=1 the second time.
- ref_req_i asserted during a port0 grant → port grant held until done_i; then ref_gnt_o=1 before port1 is served; ref_done_i clears ref_gnt_o; round-robin pointer unchanged.
- TIMEOUT_CNT=8, grant port0, never send done_i → release after 8 cycles, timeout_o single pulse, next grant goes to port1. Repeat with done_i on cycle 8 → no timeout_o.
- ena_i=0 with all requests active → no port grant; ref_req_i still yields ref_gnt_o.
- HRESETn asserted mid-PGNT → all outputs 0 immediately; after release, port0 is granted first again.
